// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The controller owns the master side: it reads op/zero/mem_ready and drives every select and strobe.
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       retire;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, retire, illegal_op, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, retire, illegal_op, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and parks in a sticky ILLEGAL state on unknown opcodes.
module multicycle_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    function automatic logic [1:0] imm_src_f(input logic [6:0] op_i);
        logic [1:0] imm_v;
        case (op_i)
            OP_SW:   imm_v = 2'b01;
            OP_BEQ:  imm_v = 2'b10;
            OP_JAL:  imm_v = 2'b11;
            default: imm_v = 2'b00;
        endcase
        return imm_v;
    endfunction

    state_t     state_r;
    state_t     next_state_s;
    logic       pc_update_s;
    logic       branch_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       reg_write_s;
    logic       retire_s;
    logic       illegal_s;

    // State register; asynchronous reset returns to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        next_state_s = state_r;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        reg_write_s  = 1'b0;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = bus.mem_ready;
                pc_update_s  = bus.mem_ready;
                if (bus.mem_ready) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_R:         next_state_s = S_EXECUTER;
                    OP_I:         next_state_s = S_EXECUTEI;
                    OP_BEQ:       next_state_s = S_BEQ;
                    OP_JAL:       next_state_s = S_JAL;
                    default:      next_state_s = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (bus.op == OP_LW) begin
                    next_state_s = S_MEMREAD;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                if (bus.mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (bus.mem_ready) begin
                    retire_s     = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_EXECUTER: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b10;
                next_state_s = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                alu_op_s     = 2'b10;
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b01;
                branch_s     = 1'b1;
                retire_s     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                pc_update_s  = 1'b1;
                next_state_s = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_s    = 1'b1;
                next_state_s = S_ILLEGAL;
            end
            // Unused encodings are treated as a fault and trapped
            default: begin
                next_state_s = S_ILLEGAL;
            end
        endcase
    end

    // Strobes are gated by rst_n so an in-flight write drops as soon as reset asserts
    assign bus.PCWrite    = rst_n & (pc_update_s | (branch_s & bus.zero));
    assign bus.IRWrite    = rst_n & ir_write_s;
    assign bus.MemWrite   = rst_n & mem_write_s;
    assign bus.RegWrite   = rst_n & reg_write_s;
    assign bus.retire     = rst_n & retire_s;
    assign bus.illegal_op = rst_n & illegal_s;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ALUOp      = alu_op_s;
    assign bus.ImmSrc     = imm_src_f(bus.op);
    assign bus.state_dbg  = state_r;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle RV32I core. Each instruction runs over several cycles through a shared ALU and a unified instruction/data memory. The block sequences fetch, decode, execute, memory and writeback, and drives every datapath select and write strobe. It supports the same instruction subset as the single-cycle main decoder: lw, sw, R-type, I-type ALU, beq and jal. It also adds a memory-ready stall and a sticky illegal-opcode trap.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode field from the instruction register. Stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  unified memory has completed or accepted the current access.
- PCWrite  out  1  PC register enable. Equal to PCUpdate | (Branch & zero).
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction register and OldPC enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A (rs1).
- ALUSrcB  out  2  00 = B (rs2), 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = subtract (compare), 10 = decode from funct fields.
- ImmSrc  out  2  immediate format. Combinational from op in every state.
- RegWrite  out  1  register file write enable.
- retire  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  out  1  high while in ILLEGAL.
- state_dbg  out  4  current state encoding, for the bench.

## Operation
- Opcodes: lw = 0000011, sw = 0100011, R-type = 0110011, I-type ALU = 0010011, beq = 1100011, jal = 1101111.
- ImmSrc mapping: lw / I-type / R-type → 00, sw → 01, beq → 10, jal → 11, any other opcode → 00.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=15.
- Any output not listed for a state is 0.
- State behaviour:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCUpdate equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (OldPC + imm into ALUOut). Next state by op:
    - lw/sw → MEMADR
    - R-type → EXECUTER
    - I-type → EXECUTEI
    - beq → BEQ
    - jal → JAL
    - any other op → ILLEGAL
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if lw, else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Wait for mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, retire=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready. On mem_ready: retire=1, go to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, retire=1. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB, which writes the link value OldPC+4.
  - ILLEGAL: all strobes 0, illegal_op=1. Only reset exits this state.
- PCUpdate and Branch are internal. Only PCWrite is exported.

## Timing
- Next state is registered; all outputs are combinational from state, op, zero and mem_ready.
- Reset: state=FETCH, asynchronously.
  - While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite, retire and illegal_op are forced to 0.
  - Select outputs take their FETCH values.
  - Reset asserted mid-instruction abandons it. A pending MemWrite drops in the same cycle.
- Latency in cycles with mem_ready tied to 1: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored in all other states.
- retire occurs exactly once per instruction and never in FETCH or DECODE.
- Simultaneous events:
  - In BEQ, PCWrite = zero in that same cycle.
  - In JAL, PCWrite=1 regardless of zero.

## Test plan
- Reset then R-type: release rst_n with op=0110011 and mem_ready=1. Required: state_dbg sequence 0,1,6,8,0. RegWrite=1 only in state 8. retire pulses once.
- lw with stall: op=0000011, mem_ready low for 2 cycles in MEMREAD. Required: sequence 0,1,2,3,3,3,4,0. AdrSrc=1 in all three state-3 cycles. ResultSrc=01 with RegWrite=1 in state 4.
- sw with fetch stall: op=0100011, mem_ready=0 for the first 3 FETCH cycles. Required: IRWrite=0 for those 3 cycles, then 1. MemWrite=1 for exactly one cycle when mem_ready=1 in state 5.
- beq: op=1100011 with zero=1, then repeat with zero=0. Required: PCWrite=1 vs 0 in state 9. ALUOp=01 both times. Each run is 3 cycles.
- jal: op=1101111. Required: sequence 0,1,10,8,0. PCWrite=1 in state 10. RegWrite=1 in state 8. ImmSrc=11 throughout.
- Illegal opcode then reset: op=1111111 in DECODE. Required: state_dbg=15, illegal_op=1, all strobes 0 for 10 cycles. Pulse rst_n low mid-cycle: state returns to 0 immediately and illegal_op=0.
